// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB line-memory slave.
package apb_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } mem_state_t;

    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_WORD = 2'b10;

    localparam int LINE_BYTES = 64;
    localparam int LINE_BITS  = LINE_BYTES * 8;

endpackage

// File: rtl/line_write_merge.sv
// Merges a right-aligned byte/half/word into a 64-byte line; untouched bytes pass through.
module line_write_merge
    import apb_mem_pkg::*;
(
    input  logic [LINE_BITS-1:0] old_line,
    input  logic [31:0]          wdata,
    input  logic [5:0]           offset,
    input  logic [1:0]           dsize,
    output logic [LINE_BITS-1:0] new_line
);

    logic [8:0] lo;

    always_comb begin
        new_line = old_line;
        lo       = '0;
        case (dsize)
            DS_BYTE: begin
                lo = {offset, 3'b000};
                new_line[lo +: 8] = wdata[7:0];
            end
            DS_HALF: begin
                lo = {offset[5:1], 4'b0000};
                new_line[lo +: 16] = wdata[15:0];
            end
            default: begin
                // dsize 2'b11 is handled as a word
                lo = {offset[5:2], 5'b00000};
                new_line[lo +: 32] = wdata;
            end
        endcase
    end

endmodule

// File: rtl/apb_line_mem_slave.sv
// APB slave returning whole 512-bit lines on read and merging byte/half/word writes.
//   state    | meaning
//   ST_IDLE  | waiting for a setup phase; request is latched on setup
//   ST_WAIT  | access phase, counting down wait states with Pready low
//   ST_READY | Pready high for one cycle; write commits at the end of it
module apb_line_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int AddWidth   = 12,
    parameter int WaitStates = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Psel,
    input  logic                 Penable,
    input  logic                 Pwrite,
    input  logic [AddWidth-1:0]  Paddr,
    input  logic [31:0]          Pwdata,
    input  logic [1:0]           dsize,
    output logic [LINE_BITS-1:0] Prdata,
    output logic                 Pready
);

    localparam int IdxW  = AddWidth - 6;
    localparam int Lines = 2 ** IdxW;

    mem_state_t            state;
    logic [3:0]            cnt;
    logic [AddWidth-1:0]   addr_q;
    logic                  wr_q;
    logic [31:0]           wdata_q;
    logic [1:0]            dsize_q;
    logic [LINE_BITS-1:0]  mem [Lines];
    logic [LINE_BITS-1:0]  merged_line;
    logic [IdxW-1:0]       idx;

    assign idx = addr_q[AddWidth-1:6];

    line_write_merge u_merge (
        .old_line (mem[idx]),
        .wdata    (wdata_q),
        .offset   (addr_q[5:0]),
        .dsize    (dsize_q),
        .new_line (merged_line)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            Pready  <= 1'b0;
            Prdata  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            dsize_q <= '0;
        end else begin
            Pready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Psel && !Penable) begin
                        addr_q  <= Paddr;
                        wr_q    <= Pwrite;
                        wdata_q <= Pwdata;
                        dsize_q <= dsize;
                        cnt     <= 4'(WaitStates);
                        if (WaitStates > 0) begin
                            state <= ST_WAIT;
                        end else begin
                            // zero wait states: READY is entered straight from setup
                            state  <= ST_READY;
                            Pready <= 1'b1;
                            if (!Pwrite)
                                Prdata <= mem[Paddr[AddWidth-1:6]];
                        end
                    end
                end
                ST_WAIT: begin
                    if (!Psel) begin
                        state <= ST_IDLE;
                    end else if (Penable) begin
                        cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1) begin
                            state  <= ST_READY;
                            Pready <= 1'b1;
                            if (!wr_q)
                                Prdata <= mem[idx];
                        end
                    end
                end
                ST_READY: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Not reset; an async reset during READY drops state so the write is skipped.
    always_ff @(posedge clk) begin
        if (state == ST_READY && wr_q)
            mem[idx] <= merged_line;
    end

endmodule
